// File: rtl/shift_wb_queue_pkg.sv
// rtl/shift_wb_queue_pkg.sv - shared types and helpers for the shifter write-back queue
package shift_wb_pkg;

  // Result widths of the 64-bit shifter/field unit.
  localparam int WB_DW = 64;
  localparam int WB_AW = 5;

  // Bit positions inside the packed flag nibble {OVR,COUT,ZERO,SIGN}.
  localparam int FLAG_OVR  = 3;
  localparam int FLAG_COUT = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_SIGN = 0;

  // One buffered shifter result.
  typedef struct packed {
    logic [WB_DW-1:0] data;
    logic [WB_AW-1:0] dst;
    logic [1:0]       size;
    logic [3:0]       flags;
  } wb_entry_t;

  // Byte enables covering the low 1/2/4/8 bytes of the operand.
  function automatic logic [7:0] size_to_be(input logic [1:0] size);
    logic [7:0] be;
    case (size)
      2'b00:   be = 8'h01;
      2'b01:   be = 8'h03;
      2'b10:   be = 8'h0F;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/shift_wb_queue_if.sv
// rtl/shift_wb_queue_if.sv - shifter result / write-back port bundle
interface shift_wb_queue_if
  import shift_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Shifter side
  logic          ISSUE;
  logic          RDY;
  logic [DW-1:0] R;
  logic [AW-1:0] DSTo;
  logic [1:0]    SR;
  logic          OVR;
  logic          ZERO;
  logic          COUT;
  logic          SIGN;

  // Write-back side
  logic          WB_GNT;
  logic          WB_REQ;
  logic [DW-1:0] WB_DATA;
  logic [AW-1:0] WB_DST;
  logic [7:0]    WB_BE;
  logic [3:0]    WB_FLAGS;

  // Status
  logic          STALL;
  logic [CW-1:0] COUNT;
  logic          ERR;

  modport master (
    output ISSUE, RDY, R, DSTo, SR, OVR, ZERO, COUT, SIGN, WB_GNT,
    input  WB_REQ, WB_DATA, WB_DST, WB_BE, WB_FLAGS, STALL, COUNT, ERR
  );

  modport slave (
    input  ISSUE, RDY, R, DSTo, SR, OVR, ZERO, COUT, SIGN, WB_GNT,
    output WB_REQ, WB_DATA, WB_DST, WB_BE, WB_FLAGS, STALL, COUNT, ERR
  );

endinterface

// File: rtl/shift_wb_queue_fifo.sv
// rtl/shift_wb_queue_fifo.sv - show-ahead FIFO of write-back entries
module wb_fifo
  import shift_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_entry_t     wr_entry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop on an empty queue is meaningless; a push into a full queue only
  // lands when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/shift_wb_queue.sv
// rtl/shift_wb_queue.sv - shifter result queue feeding the register-file write-back port
module shift_wb_queue
  import shift_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
) (
  input  logic             CLK,
  input  logic             RESET,
  shift_wb_queue_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] INF_MAX = '1;

  wb_entry_t     wr_entry;
  wb_entry_t     head;
  logic [3:0]    flags_in;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          req;
  logic          pop_taken;
  logic          drop;

  logic [CW-1:0] inf;
  logic [CW-1:0] inf_nxt;
  logic          rdy_orphan;
  logic [CW:0]   occ;
  logic          err;

  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_dst;
  logic [7:0]    wb_be;
  logic [3:0]    wb_flags;

  // Pack the shifter flags into their fixed nibble positions.
  always_comb begin
    flags_in            = '0;
    flags_in[FLAG_OVR]  = bus.OVR;
    flags_in[FLAG_COUT] = bus.COUT;
    flags_in[FLAG_ZERO] = bus.ZERO;
    flags_in[FLAG_SIGN] = bus.SIGN;
  end

  assign wr_entry = '{data: bus.R, dst: bus.DSTo, size: bus.SR, flags: flags_in};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (CLK),
    .rst_n    (RESET),
    .push     (bus.RDY),
    .wr_entry (wr_entry),
    .pop      (bus.WB_GNT),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign req       = ~empty;
  assign pop_taken = req & bus.WB_GNT;
  // The shifter cannot be held off, so a result arriving at a full queue
  // with no departing head is lost.
  assign drop      = bus.RDY & full & ~pop_taken;

  // In-flight credit update; an unmatched RDY leaves the counter at zero.
  always_comb begin
    inf_nxt    = inf;
    rdy_orphan = 1'b0;
    case ({bus.ISSUE, bus.RDY})
      2'b10: begin
        if (inf != INF_MAX) inf_nxt = inf + CW'(1);
      end
      2'b01: begin
        if (inf == '0) rdy_orphan = 1'b1;
        else           inf_nxt    = inf - CW'(1);
      end
      default: inf_nxt = inf;
    endcase
  end

  // In-flight counter register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) inf <= '0;
    else        inf <= inf_nxt;
  end

  // Sticky protocol error: lost result or RDY with nothing outstanding.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                 err <= 1'b0;
    else if (drop | rdy_orphan) err <= 1'b1;
  end

  // Stall reserves a slot for every queued and every outstanding result;
  // deliberately ignores a pop in the current cycle.
  assign occ = {1'b0, count} + {1'b0, inf};

  // Head presentation, forced to zero while nothing is queued.
  always_comb begin
    wb_data  = '0;
    wb_dst   = '0;
    wb_be    = '0;
    wb_flags = '0;
    if (req) begin
      wb_data  = head.data;
      wb_dst   = head.dst;
      wb_be    = size_to_be(head.size);
      wb_flags = head.flags;
    end
  end

  assign bus.WB_REQ   = req;
  assign bus.WB_DATA  = wb_data;
  assign bus.WB_DST   = wb_dst;
  assign bus.WB_BE    = wb_be;
  assign bus.WB_FLAGS = wb_flags;
  assign bus.STALL    = (occ >= (CW+1)'(DEPTH));
  assign bus.COUNT    = count;
  assign bus.ERR      = err;

endmodule

// File: tb/tb_shift_wb_queue.sv
// tb/tb_shift_wb_queue.sv - scoreboard bench for shift_wb_queue
module tb_shift_wb_queue;
  import shift_wb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_wb_queue_if #(.DEPTH(DEPTH)) bus ();

  shift_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  dst;
    logic [7:0]  be;
    logic [3:0]  flags;
  } head_t;

  typedef struct {
    bit    req;
    head_t head;
    int    count;
    bit    stall;
    bit    err;
  } exp_t;

  head_t model_q[$];
  int    model_inf;
  bit    model_err;
  exp_t  exp_q[$];
  int    checks = 0;
  int    passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  function automatic head_t zero_head();
    head_t h;
    h.data = '0; h.dst = '0; h.be = '0; h.flags = '0;
    return h;
  endfunction

  function automatic bit model_stall();
    return (model_q.size() + model_inf) >= DEPTH;
  endfunction

  task automatic drive_idle();
    bus.ISSUE = 0; bus.RDY = 0; bus.WB_GNT = 0;
    bus.R = '0; bus.DSTo = '0; bus.SR = 2'b11;
    bus.OVR = 0; bus.COUT = 0; bus.ZERO = 0; bus.SIGN = 0;
  endtask

  // One clock of stimulus: records what the DUT must show this cycle, then
  // advances the reference model by this cycle's inputs.
  task automatic cycle(input bit issue, input bit rdy, input bit gnt,
                       input logic [63:0] r = '0, input logic [4:0] dst = '0,
                       input logic [1:0] sr = 2'b11, input logic [3:0] fl = '0);
    exp_t  e;
    head_t n;
    int    nbytes;
    @(negedge clk);
    bus.ISSUE = issue; bus.RDY = rdy; bus.WB_GNT = gnt;
    bus.R = r; bus.DSTo = dst; bus.SR = sr;
    bus.OVR = fl[3]; bus.COUT = fl[2]; bus.ZERO = fl[1]; bus.SIGN = fl[0];
    e.req   = model_q.size() > 0;
    e.head  = e.req ? model_q[0] : zero_head();
    e.count = model_q.size();
    e.stall = model_stall();
    e.err   = model_err;
    exp_q.push_back(e);
    if (e.req && gnt) n = model_q.pop_front();
    if (rdy) begin
      if (model_q.size() == DEPTH) model_err = 1;
      else begin
        nbytes  = 1 << sr;
        n.data  = r;
        n.dst   = dst;
        n.be    = 8'((1 << nbytes) - 1);
        n.flags = fl;
        model_q.push_back(n);
      end
    end
    if (issue && !rdy) model_inf++;
    else if (rdy && !issue) begin
      if (model_inf == 0) model_err = 1;
      else model_inf--;
    end
  endtask

  task automatic rand_result(input bit issue, input bit gnt);
    cycle(issue, 1, gnt, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
  endtask

  task automatic random_legal(input int n);
    bit iss, rdy;
    for (int i = 0; i < n; i++) begin
      iss = !model_stall() && ($urandom_range(0, 1) == 1);
      rdy = (model_inf > 0) && ($urandom_range(0, 1) == 1);
      if (rdy) rand_result(iss, $urandom_range(0, 1) == 1);
      else     cycle(iss, 0, $urandom_range(0, 1) == 1);
    end
    while (model_inf > 0) rand_result(0, 1);
    repeat (DEPTH + 1) cycle(0, 0, 1);
  endtask

  // Asynchronous reset between clock edges with work still queued.
  task automatic reset_mid();
    exp_t e;
    @(negedge clk);
    drive_idle();
    #2 rst_n = 0;
    #1;
    check("rst_wb_req", bus.WB_REQ, 0);
    check("rst_count", bus.COUNT, 0);
    check("rst_stall", bus.STALL, 0);
    check("rst_err", bus.ERR, 0);
    model_q.delete();
    model_inf = 0;
    model_err = 0;
    e.req = 0; e.head = zero_head(); e.count = 0; e.stall = 0; e.err = 0;
    exp_q.push_back(e);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic scenario_single();
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0, 64'h0123456789ABCDEF, 5'd7, 2'b11, 4'b0000);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
  endtask

  // Monitor: compares the DUT against the queued expectation just before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_req", bus.WB_REQ, e.req);
        check("wb_data", bus.WB_DATA, e.head.data);
        check("wb_dst", bus.WB_DST, e.head.dst);
        check("wb_be", bus.WB_BE, e.head.be);
        check("wb_flags", bus.WB_FLAGS, e.head.flags);
        check("count", bus.COUNT, e.count);
        check("stall", bus.STALL, e.stall);
        check("err", bus.ERR, e.err);
      end
    end
  end

  initial begin
    model_inf = 0;
    model_err = 0;
    rst_n = 0;
    drive_idle();
    #1;
    check("init_wb_req", bus.WB_REQ, 0);
    check("init_count", bus.COUNT, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    scenario_single();

    // Credits alone fill the stall window, then results fill the queue.
    repeat (4) cycle(1, 0, 0);
    cycle(0, 0, 0);
    repeat (4) rand_result(0, 0);
    cycle(0, 0, 0);

    // Full queue: push and pop together keep it full, across pointer wrap.
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, 0);
      rand_result(0, 1);
    end
    repeat (5) cycle(0, 0, 1);

    // Push into an empty queue with a grant: not bypassed.
    cycle(1, 0, 0);
    rand_result(0, 1);
    cycle(0, 0, 1);

    // Operand sizes with OVR and COUT set.
    for (int s = 0; s < 3; s++) begin
      cycle(1, 0, 0);
      cycle(0, 1, 0, {$urandom, $urandom}, 5'(s + 3), 2'(s), 4'b1100);
      cycle(0, 0, 1);
    end

    random_legal(150);

    // Overflow: illegal issue while full and stalled, result is dropped.
    repeat (4) cycle(1, 0, 0);
    repeat (4) rand_result(0, 0);
    cycle(1, 0, 0);
    rand_result(0, 0);
    cycle(0, 0, 0);
    random_legal(30);

    // Reset with three entries queued and two results outstanding.
    repeat (4) cycle(1, 0, 0);
    repeat (3) rand_result(0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    reset_mid();
    scenario_single();
    random_legal(100);

    // RDY with nothing outstanding: still queued, error raised.
    rand_result(0, 0);
    repeat (3) cycle(0, 0, 1);

    @(negedge clk);
    #6;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shift_wb_queue.md
Name: shift_wb_queue

Overview:
Downstream stage of the 64-bit shifter/field unit. Captures each completed shifter result (data, destination, operand size, flags) and buffers it in a small FIFO. Drains the FIFO into the shared register-file write-back port under an external grant. Tracks in-flight shifter operations so the issue stage stalls before the queue can overflow.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, 2..16)
DW, 64, result data width
AW, 5, destination register index width

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
ISSUE  input  1  an operation is accepted into the shifter this cycle (ACT of shifter)
RDY  input  1  shifter result valid this cycle
R  input  DW  shifter result
DSTo  input  AW  shifter destination index
SR  input  2  result operand size: 00=8, 01=16, 10=32, 11=64 bit
OVR, ZERO, COUT, SIGN  input  1 each  shifter flags
WB_GNT  input  1  write-back arbiter grant
WB_REQ  output  1  head entry valid, requesting write-back
WB_DATA  output  DW  head data
WB_DST  output  AW  head destination
WB_BE  output  8  head byte enables
WB_FLAGS  output  4  head flags {OVR,COUT,ZERO,SIGN}
STALL  output  1  issue stage must not assert ISSUE
COUNT  output  $clog2(DEPTH)+1  current occupancy
ERR  output  1  sticky protocol error

Behaviour:
- Reset (RESET=0, async): read/write pointers, COUNT, in-flight counter, ERR cleared; WB_REQ=0, WB_DATA/WB_DST/WB_BE/WB_FLAGS=0, STALL=0. Reset mid-operation discards all entries and in-flight credits.
- Push: RDY=1 writes {R,DSTo,SR,flags} at write pointer. No backpressure to the shifter.
- Show-ahead FIFO: head visible on WB_* outputs whenever COUNT>0. WB_REQ = (COUNT!=0). Head fields are gated to 0 when WB_REQ=0.
- Pop: WB_REQ & WB_GNT in a cycle removes the head. WB_GNT with WB_REQ=0 is ignored.
- Latency: a result pushed in cycle n appears on WB_* in cycle n+1 if the FIFO was empty.
- Simultaneous push and pop: COUNT unchanged; legal when full (pop frees the slot) and when empty (entry is written, not bypassed; visible in the next cycle).
- Push while full without pop: result dropped, ERR set.
- Pointers wrap modulo DEPTH; COUNT range 0..DEPTH.
- WB_BE from SR: 00->8'h01, 01->8'h03, 10->8'h0F, 11->8'hFF. Data is passed unmodified.
- In-flight counter INF (width as COUNT): +1 on ISSUE, -1 on RDY, unchanged on both.
- RDY with INF=0 and no ISSUE: INF stays 0 and ERR is set.
- STALL = (COUNT + INF) >= DEPTH, computed from registered state, no pop lookahead.
- ISSUE while STALL=1 is illegal. It is still counted, so any resulting drop raises ERR.
- ERR is sticky until reset.

Decomposition:
- Package shift_wb_pkg:
  - typedef wb_entry_t struct {data[DW], dst[AW], size[1:0], flags[3:0]}
  - function size_to_be(size) -> [7:0]
  - localparams for flag bit positions (OVR=3, COUT=2, ZERO=1, SIGN=0)
- Sub-module wb_fifo: generic show-ahead FIFO of wb_entry_t with push/pop/count/full/empty and async active-low reset.
- Top level adds the in-flight counter, STALL, BE/flag packing, output gating and ERR.

Test Plan:
1. Reset, then ISSUE in cycle 0; RDY with R=64'h0123456789ABCDEF, DSTo=7, SR=11, ZERO=0, SIGN=0 in cycle 3 -> cycle 4: WB_REQ=1, WB_DATA=64'h0123456789ABCDEF, WB_DST=7, WB_BE=8'hFF, WB_FLAGS=4'b0000; WB_GNT=1 in cycle 4 -> cycle 5: WB_REQ=0, COUNT=0.
2. Four ISSUEs in consecutive cycles with WB_GNT=0 (DEPTH=4) -> STALL=1 after the 4th ISSUE while COUNT=0, INF=4. As RDYs arrive: COUNT rises to 4, INF falls to 0, STALL stays 1, ERR=0.
3. FIFO full (4 entries); RDY together with WB_REQ&WB_GNT -> COUNT stays 4, new entry lands at tail, ERR=0. Drain order matches push order across pointer wrap.
4. FIFO full; RDY with WB_GNT=0 -> entry dropped, ERR=1 and stays 1 through subsequent normal traffic until RESET.
5. Sizes SR=00/01/10 with flags OVR=1, COUT=1 -> WB_BE=8'h01/8'h03/8'h0F, WB_FLAGS=4'b1100.
6. Assert RESET with 3 entries queued and INF=2 -> immediately WB_REQ=0, COUNT=0, STALL=0. After release, a new single ISSUE/RDY pair flows through as in scenario 1 and ERR=0.
